// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Upper bound on producers; sizes the one-hot helper.
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // One-hot encode a producer index; callers cast down to their own width.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
        return vec;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after last_owner,
// scanning upward and wrapping modulo NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] cand_s;

    // Scan from the farthest candidate back to the nearest so the nearest hit wins.
    always_comb begin
        valid  = 1'b0;
        index  = {IDX_W{1'b0}};
        cand_s = {IDX_W{1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            valid  = valid | req[cand_s];
            index  = req[cand_s] ? cand_s : index;
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port between
// NUM_REQ producers. Writes are acknowledged in the same cycle they occur.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_write_data,
    input  logic                      fifo_full,
    input  logic                      fifo_read_en,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    // Producer 0 is scanned first after reset.
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t           state_r,      state_s;
    logic [NUM_REQ-1:0]   grant_r,      grant_s;
    logic [CNT_W-1:0]     burst_cnt_r,  burst_cnt_s;
    logic [IDX_W-1:0]     last_owner_r, last_owner_s;
    logic [IDX_W-1:0]     owner_r,      owner_s;

    logic                 pick_valid_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic                 space_s;
    logic                 accept_s;
    logic [DATA_W-1:0]    owner_data_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_r),
        .valid      (pick_valid_s),
        .index      (pick_idx_s)
    );

    // A full FIFO still takes a write when it is being read in the same cycle.
    assign space_s  = !fifo_full || fifo_read_en;
    assign accept_s = (state_r == BURST) && req[owner_r] && space_s && !rst;
    assign grant    = grant_r;
    assign busy     = (state_r == BURST);

    // Select the current owner's data slice.
    always_comb begin
        owner_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_data_s = (owner_r == IDX_W'(i)) ? req_data[i*DATA_W +: DATA_W] : owner_data_s;
        end
    end

    // Write port and ack drive; everything is held at zero during reset.
    always_comb begin
        fifo_write_en   = accept_s;
        ack             = {NUM_REQ{1'b0}};
        fifo_write_data = {DATA_W{1'b0}};
        if (accept_s) begin
            ack = NUM_REQ'(onehot(MAX_IDX_W'(owner_r)));
        end else begin
            ack = {NUM_REQ{1'b0}};
        end
        if ((state_r == BURST) && !rst) begin
            fifo_write_data = owner_data_s;
        end else begin
            fifo_write_data = {DATA_W{1'b0}};
        end
    end

    // Next-state logic: grant on IDLE, count/stall/release in BURST.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        burst_cnt_s  = burst_cnt_r;
        last_owner_s = last_owner_r;
        owner_s      = owner_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s     = BURST;
                    grant_s     = NUM_REQ'(onehot(MAX_IDX_W'(pick_idx_s)));
                    burst_cnt_s = {CNT_W{1'b0}};
                    owner_s     = pick_idx_s;
                end else begin
                    state_s     = IDLE;
                end
            end
            BURST: begin
                if (accept_s && (burst_cnt_r == CNT_LAST)) begin
                    state_s      = IDLE;
                    grant_s      = {NUM_REQ{1'b0}};
                    burst_cnt_s  = {CNT_W{1'b0}};
                    last_owner_s = owner_r;
                end else if (accept_s) begin
                    burst_cnt_s  = burst_cnt_r + CNT_W'(1);
                end else if (!req[owner_r]) begin
                    // Owner withdrew: release without writing.
                    state_s      = IDLE;
                    grant_s      = {NUM_REQ{1'b0}};
                    burst_cnt_s  = {CNT_W{1'b0}};
                    last_owner_s = owner_r;
                end else begin
                    // FIFO full with no read: hold everything.
                    state_s      = BURST;
                end
            end
            default: begin
                state_s      = IDLE;
                grant_s      = {NUM_REQ{1'b0}};
                burst_cnt_s  = {CNT_W{1'b0}};
                last_owner_s = LAST_RST;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_r      <= {NUM_REQ{1'b0}};
            burst_cnt_r  <= {CNT_W{1'b0}};
            last_owner_r <= LAST_RST;
            owner_r      <= {IDX_W{1'b0}};
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            burst_cnt_r  <= burst_cnt_s;
            last_owner_r <= last_owner_s;
            owner_r      <= owner_s;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter. Expected writes are queued by the
// stimulus with the cycle they must appear in; monitors pop on each write.
module tb_fifo_write_arbiter;

    typedef struct {
        int         cyc;
        logic [3:0] ack;
        logic [3:0] data;
    } exp_t;

    logic clk;
    int   cyc;
    int   n_vec;
    int   n_fail;
    exp_t qa[$];
    exp_t qb[$];

    // DUT A: NUM_REQ=4, DATA_W=4, MAX_BURST=2
    logic        rst_a, full_a, rd_a, wen_a, busy_a;
    logic [3:0]  req_a, ack_a, grant_a, wdata_a;
    logic [15:0] rdata_a;

    // DUT B: NUM_REQ=3, DATA_W=4, MAX_BURST=1
    logic        rst_b, full_b, rd_b, wen_b, busy_b;
    logic [2:0]  req_b, ack_b, grant_b;
    logic [3:0]  wdata_b;
    logic [11:0] rdata_b;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(4), .MAX_BURST(2)) dut (
        .clk(clk), .rst(rst_a), .req(req_a), .req_data(rdata_a), .ack(ack_a),
        .grant(grant_a), .fifo_write_en(wen_a), .fifo_write_data(wdata_a),
        .fifo_full(full_a), .fifo_read_en(rd_a), .busy(busy_a)
    );

    fifo_write_arbiter #(.NUM_REQ(3), .DATA_W(4), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .req_data(rdata_b), .ack(ack_b),
        .grant(grant_b), .fifo_write_en(wen_b), .fifo_write_data(wdata_b),
        .fifo_full(full_b), .fifo_read_en(rd_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor A: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (wen_a === 1'b1) begin
            n_vec++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL wr_a_unexpected cyc=%0d ack=%b data=%h", cyc, ack_a, wdata_a);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (e.cyc != cyc || ack_a !== e.ack || wdata_a !== e.data) begin
                    n_fail++;
                    $display("FAIL wr_a got cyc=%0d ack=%b data=%h exp cyc=%0d ack=%b data=%h",
                             cyc, ack_a, wdata_a, e.cyc, e.ack, e.data);
                end
            end
        end
    end

    // Monitor B: same as A for the 3-producer instance.
    always @(negedge clk) begin
        if (wen_b === 1'b1) begin
            n_vec++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL wr_b_unexpected cyc=%0d ack=%b data=%h", cyc, ack_b, wdata_b);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (e.cyc != cyc || {1'b0, ack_b} !== e.ack || wdata_b !== e.data) begin
                    n_fail++;
                    $display("FAIL wr_b got cyc=%0d ack=%b data=%h exp cyc=%0d ack=%b data=%h",
                             cyc, ack_b, wdata_b, e.cyc, e.ack, e.data);
                end
            end
        end
    end

    // Drive one cycle of DUT A and check grant/busy/write_en for that cycle.
    task automatic step_a(input logic r, input logic [3:0] rq, input logic f, input logic rd,
                          input logic [3:0] g, input logic wr, input logic [3:0] ak,
                          input logic [3:0] d);
        @(posedge clk);
        #1;
        rst_a = r; req_a = rq; full_a = f; rd_a = rd;
        if (wr) qa.push_back('{cyc, ak, d});
        @(negedge clk);
        n_vec++;
        if (grant_a !== g || busy_a !== (g != 4'b0000) || wen_a !== wr || (!wr && ack_a !== 4'b0000)) begin
            n_fail++;
            $display("FAIL step_a cyc=%0d got grant=%b busy=%b wen=%b ack=%b exp grant=%b wen=%b",
                     cyc, grant_a, busy_a, wen_a, ack_a, g, wr);
        end
    endtask

    // Drive one cycle of DUT B and check its grant/busy/write_en.
    task automatic step_b(input logic r, input logic [2:0] rq, input logic [2:0] g,
                          input logic wr, input logic [2:0] ak, input logic [3:0] d);
        @(posedge clk);
        #1;
        rst_b = r; req_b = rq;
        if (wr) qb.push_back('{cyc, {1'b0, ak}, d});
        @(negedge clk);
        n_vec++;
        if (grant_b !== g || busy_b !== (g != 3'b000) || wen_b !== wr || (!wr && ack_b !== 3'b000)) begin
            n_fail++;
            $display("FAIL step_b cyc=%0d got grant=%b busy=%b wen=%b ack=%b exp grant=%b wen=%b",
                     cyc, grant_b, busy_b, wen_b, ack_b, g, wr);
        end
    endtask

    initial begin
        logic [3:0] og;
        logic [2:0] ogb;
        cyc = 0; n_vec = 0; n_fail = 0;
        rst_a = 1'b1; req_a = 4'b0000; full_a = 1'b0; rd_a = 1'b0;
        rdata_a = {4'hD, 4'hC, 4'hB, 4'hA};
        rst_b = 1'b1; req_b = 3'b000; full_b = 1'b0; rd_b = 1'b0;
        rdata_b = {4'h7, 4'h6, 4'h5};

        // Reset state
        step_a(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);
        step_a(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);

        // Single producer 0: grant, two acks, back to IDLE
        step_a(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);
        step_a(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'hA);
        step_a(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'hA);
        step_a(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);

        // All requesting: order 0,1,2,3,0 with an IDLE bubble between grants
        step_a(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);
        for (int g = 0; g < 5; g++) begin
            og = 4'b0001 << (g % 4);
            step_a(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);
            step_a(1'b0, 4'b1111, 1'b0, 1'b0, og, 1'b1, og, 4'hA + 4'(g % 4));
            step_a(1'b0, 4'b1111, 1'b0, 1'b0, og, 1'b1, og, 4'hA + 4'(g % 4));
        end
        step_a(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);

        // Owner 2 stalls on full, then writes when a read coincides
        step_a(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);
        for (int s = 0; s < 5; s++) begin
            step_a(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 4'h0, 4'h0);
        end
        step_a(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 4'hC);
        step_a(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hC);
        step_a(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);

        // Owner 1 withdraws after one write; producer 3 beats producer 0
        step_a(1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);
        step_a(1'b0, 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010, 4'hB);
        step_a(1'b0, 4'b1000, 1'b0, 1'b0, 4'b0010, 1'b0, 4'h0, 4'h0);
        step_a(1'b0, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);
        step_a(1'b0, 4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000, 4'hD);
        step_a(1'b0, 4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000, 4'hD);
        step_a(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);

        // Burst of 0 (last_owner=0), then owner 1 reset mid-burst
        step_a(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);
        step_a(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'hA);
        step_a(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'hA);
        step_a(1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);
        step_a(1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010, 4'hB);
        step_a(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 4'h0, 4'h0);
        // After reset producer 0 must win over producer 1
        step_a(1'b0, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);
        step_a(1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'hA);
        step_a(1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'hA);
        step_a(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 4'h0);

        // NUM_REQ=3, MAX_BURST=1: grants 0,1,2,0 with one ack each
        step_b(1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 4'h0);
        for (int g = 0; g < 4; g++) begin
            ogb = 3'b001 << (g % 3);
            step_b(1'b0, 3'b111, 3'b000, 1'b0, 3'b000, 4'h0);
            step_b(1'b0, 3'b111, ogb, 1'b1, ogb, 4'h5 + 4'(g % 3));
        end
        step_b(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 4'h0);

        // Every expected write must have been seen
        @(negedge clk);
        n_vec++;
        if (qa.size() != 0) begin
            n_fail++;
            $display("FAIL qa_drain got %0d pending exp 0", qa.size());
        end
        n_vec++;
        if (qb.size() != 0) begin
            n_fail++;
            $display("FAIL qb_drain got %0d pending exp 0", qb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
